// File: rtl/ex_mem_stage_pkg.sv
// Shared EX/MEM definitions: default widths, control bit positions and the
// packed bundle that travels through the stage's skid buffer.
package ex_mem_stage_pkg;

    localparam int DATA_W        = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int CTL_W         = 4;

    localparam int CTL_REG_WRITE = 3;
    localparam int CTL_MEM_READ  = 2;
    localparam int CTL_MEM_WRITE = 1;
    localparam int CTL_BRANCH    = 0;

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [CTL_W-1:0]      ctl;
        logic                  zero;
        logic [DATA_W-1:0]     target;
    } ex_mem_bundle_t;

    localparam int BUNDLE_W = $bits(ex_mem_bundle_t);

    // Bundle width for non-default parameterisations, same field order as the struct.
    function automatic int bundle_width(input int data_w, input int reg_addr_w);
        return 3 * data_w + reg_addr_w + CTL_W + 1;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry skid buffer: head register drives the outputs, skid register
// absorbs one extra beat so in_ready can be a pure register.
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         head_valid_reg, head_valid_next;
    logic         skid_valid_reg, skid_valid_next;
    logic [W-1:0] head_data_reg, head_data_next;
    logic [W-1:0] skid_data_reg, skid_data_next;
    logic         in_ready_reg;
    logic         xfer_in;
    logic         xfer_out;

    assign xfer_in  = in_valid && in_ready_reg;
    assign xfer_out = head_valid_reg && out_ready;

    always_comb begin
        head_valid_next = head_valid_reg;
        skid_valid_next = skid_valid_reg;
        head_data_next  = head_data_reg;
        skid_data_next  = skid_data_reg;
        if (flush) begin
            head_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            if (xfer_out) begin
                if (skid_valid_reg) begin
                    head_data_next  = skid_data_reg;
                    skid_valid_next = 1'b0;
                end else begin
                    head_valid_next = 1'b0;
                end
            end
            // in_ready is !skid_valid, so an accepted beat never races a skid->head move.
            if (xfer_in) begin
                if (!head_valid_reg || (xfer_out && !skid_valid_reg)) begin
                    head_data_next  = in_data;
                    head_valid_next = 1'b1;
                end else begin
                    skid_data_next  = in_data;
                    skid_valid_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            head_data_reg  <= '0;
            skid_data_reg  <= '0;
            in_ready_reg   <= 1'b1;
        end else begin
            head_valid_reg <= head_valid_next;
            skid_valid_reg <= skid_valid_next;
            head_data_reg  <= head_data_next;
            skid_data_reg  <= skid_data_next;
            in_ready_reg   <= !skid_valid_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = head_valid_reg;
    assign out_data  = head_data_reg;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built on a skid buffer; adds branch resolution and
// zeroes every head field while the head is empty.
module ex_mem_stage #(
    parameter int DATA_W     = ex_mem_stage_pkg::DATA_W,
    parameter int REG_ADDR_W = ex_mem_stage_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  zero_flag,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [3:0]            ctl_in,
    input  logic [DATA_W-1:0]     branch_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [3:0]            out_ctl,
    output logic [DATA_W-1:0]     out_target,
    output logic                  branch_taken
);

    import ex_mem_stage_pkg::*;

    localparam int BW = bundle_width(DATA_W, REG_ADDR_W);

    logic [BW-1:0]         in_bundle;
    logic [BW-1:0]         head_bundle;
    logic [BW-1:0]         gated_bundle;
    logic                  head_valid;
    logic                  head_zero;

    assign in_bundle = {alu_result, store_data, rd_addr, ctl_in, zero_flag, branch_target};

    pipe_skid_reg #(
        .W(BW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_bundle),
        .out_valid(head_valid),
        .out_ready(out_ready),
        .out_data (head_bundle)
    );

    // Stale data may linger in the head after a flush; mask it bit by bit.
    generate
        for (genvar gi = 0; gi < BW; gi++) begin : g_gate
            assign gated_bundle[gi] = head_bundle[gi] & head_valid;
        end
    endgenerate

    assign {out_result, out_store_data, out_rd, out_ctl, head_zero, out_target} = gated_bundle;

    assign out_valid    = head_valid;
    assign branch_taken = out_ctl[CTL_BRANCH] & head_zero;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: driver pushes expected bundles on accept,
// monitor pops and compares on every output handshake.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        zero_flag;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic [3:0]  ctl_in;
    logic [31:0] branch_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic [3:0]  out_ctl;
    logic [31:0] out_target;
    logic        branch_taken;

    typedef struct {
        logic [31:0] result;
        logic [31:0] store;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic [31:0] target;
        logic        taken;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_seen   = 0;
    int   run_len  = 0;
    int   max_run  = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .zero_flag     (zero_flag),
        .store_data    (store_data),
        .rd_addr       (rd_addr),
        .ctl_in        (ctl_in),
        .branch_target (branch_target),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_store_data(out_store_data),
        .out_rd        (out_rd),
        .out_ctl       (out_ctl),
        .out_target    (out_target),
        .branch_taken  (branch_taken)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd,
                        input logic [3:0] ctl, input logic z, input logic [31:0] tgt);
        exp_t e;
        bit   done;
        done          = 1'b0;
        in_valid      = 1'b1;
        alu_result    = res;
        store_data    = sd;
        rd_addr       = rd;
        ctl_in        = ctl;
        zero_flag     = z;
        branch_target = tgt;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.result = res;
                e.store  = sd;
                e.rd     = rd;
                e.ctl    = ctl;
                e.target = tgt;
                e.taken  = ctl[0] & z;
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected accept of result=%h", res);
        end
    endtask

    // Monitor: a handshake visible at the negedge completes on the next posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                run_len = 0;
            end else begin
                run_len = out_valid ? run_len + 1 : 0;
                if (run_len > max_run) max_run = run_len;
                if (out_valid && out_ready && !flush) begin
                    n_seen++;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_output: got result=%h expected no output", out_result);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_result", 64'(out_result), 64'(e.result));
                        check("out_store_data", 64'(out_store_data), 64'(e.store));
                        check("out_rd", 64'(out_rd), 64'(e.rd));
                        check("out_ctl", 64'(out_ctl), 64'(e.ctl));
                        check("out_target", 64'(out_target), 64'(e.target));
                        check("branch_taken", 64'(branch_taken), 64'(e.taken));
                        $display("txn %0d: result=%h store=%h rd=%0d ctl=%b target=%h taken=%b",
                                 n_seen, out_result, out_store_data, out_rd, out_ctl, out_target, branch_taken);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_result = '0; zero_flag = 1'b0; store_data = '0; rd_addr = '0;
        ctl_in = '0; branch_target = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_ctl", 64'(out_ctl), 64'd0);
        check("rst_branch_taken", 64'(branch_taken), 64'd0);
        check("rst_out_target", 64'(out_target), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single ALU bundle, one-cycle latency
        out_ready = 1'b1;
        send(32'h10, 32'hAAAA_0001, 5'd3, 4'b1000, 1'b0, 32'h0);
        @(negedge clk);
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_out_result", 64'(out_result), 64'h10);
        @(posedge clk); #1;

        // Branch taken / not taken
        send(32'h0, 32'h0, 5'd0, 4'b0001, 1'b1, 32'h40);
        @(negedge clk);
        check("beq_taken", 64'(branch_taken), 64'd1);
        check("beq_target", 64'(out_target), 64'h40);
        @(posedge clk); #1;
        send(32'h5, 32'h0, 5'd0, 4'b0001, 1'b0, 32'h40);
        @(negedge clk);
        check("beq_not_taken", 64'(branch_taken), 64'd0);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: A, B fill the stage, C held off
        out_ready = 1'b0;
        send(32'h1, 32'h11, 5'd1, 4'b1000, 1'b0, 32'h100);
        send(32'h2, 32'h22, 5'd2, 4'b0100, 1'b0, 32'h200);
        in_valid = 1'b1; alu_result = 32'h3; store_data = 32'h33; rd_addr = 5'd3;
        ctl_in = 4'b0010; zero_flag = 1'b0; branch_target = 32'h300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_hold_result", 64'(out_result), 64'h1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'h3, 32'h33, 5'd3, 4'b0010, 1'b0, 32'h300);
        repeat (3) @(posedge clk);
        #1;
        check("bp_drained", 64'(sb_q.size()), 64'd0);

        // Flush with a full stage and a simultaneous offer
        out_ready = 1'b0;
        send(32'h11, 32'h0, 5'd4, 4'b1000, 1'b0, 32'h0);
        send(32'h22, 32'h0, 5'd5, 4'b1000, 1'b0, 32'h0);
        in_valid = 1'b1; alu_result = 32'h33; ctl_in = 4'b0001; zero_flag = 1'b1;
        flush = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_result", 64'(out_result), 64'd0);
        check("flush_out_ctl", 64'(out_ctl), 64'd0);
        check("flush_branch_taken", 64'(branch_taken), 64'd0);
        out_ready = 1'b1;
        seen0 = n_seen;
        repeat (4) @(negedge clk);
        check("flush_c_discarded", 64'(n_seen - seen0), 64'd0);
        @(posedge clk); #1;

        // Back-to-back stream of 8
        max_run = 0;
        seen0 = n_seen;
        for (int i = 0; i < 8; i++)
            send(32'h100 + 32'(i), 32'h5000 + 32'(i), 5'(i + 8), 4'b1000, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("stream_count", 64'(n_seen - seen0), 64'd8);
        check("stream_consecutive", 64'(max_run), 64'd8);
        @(posedge clk); #1;

        // Reset mid-stall overrides flush and handshake
        out_ready = 1'b0;
        send(32'hAB, 32'hCD, 5'd7, 4'b1001, 1'b1, 32'hEF);
        send(32'h12, 32'h34, 5'd9, 4'b0101, 1'b1, 32'h56);
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; alu_result = 32'h99; ctl_in = 4'b1111;
        sb_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_result", 64'(out_result), 64'd0);
        check("mid_rst_out_store", 64'(out_store_data), 64'd0);
        check("mid_rst_out_rd", 64'(out_rd), 64'd0);
        check("mid_rst_out_ctl", 64'(out_ctl), 64'd0);
        check("mid_rst_out_target", 64'(out_target), 64'd0);
        check("mid_rst_branch_taken", 64'(branch_taken), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
